// File: rtl/aes_enc_core.sv
// Iterative AES-128 encryption core.
// Each clock runs one full round using forward T-box lookups (Te0), and the
// round key is expanded on the fly alongside it. The block is accepted over an
// in_valid/in_ready handshake and the result is returned over out_valid/out_ready.

// Forward T-box Te0: t = {02*S(x), S(x), S(x), 03*S(x)}, MSB first.
// S(x) is computed arithmetically (GF(2^8) inverse followed by the affine map),
// so no 256-entry constant table has to be kept in the source.
module aes_tbox_f (
    input  logic [7:0]  x,
    output logic [31:0] t
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); it also maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] inv_b;
    logic [7:0] sbox_b;
    logic [7:0] sbox_x2;

    // S-box value and its doubled form, packed into the Te0 word.
    always_comb begin
        inv_b   = gf_inv(x);
        sbox_b  = inv_b ^ {inv_b[6:0], inv_b[7]} ^ {inv_b[5:0], inv_b[7:6]}
                ^ {inv_b[4:0], inv_b[7:5]} ^ {inv_b[3:0], inv_b[7:4]} ^ 8'h63;
        sbox_x2 = xtime(sbox_b);
        t       = {sbox_x2, sbox_b, sbox_b, sbox_x2 ^ sbox_b};
    end

endmodule

module aes_enc_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_reg, state_next;
    logic [127:0] st_reg;
    logic [127:0] rk_reg;
    logic [127:0] ct_reg;
    logic [3:0]   rnd_reg;
    logic [7:0]   rcon_reg;

    logic         accept;
    logic         last_round;

    // te[column][byte]: Te0 of byte b taken from word (column + b) mod 4,
    // which folds ShiftRows into the table addressing.
    logic [31:0]  te [4][4];
    logic [31:0]  col_mix [4];
    logic [31:0]  col_last [4];
    logic [31:0]  key_te [4];
    logic [7:0]   sub_b [4];

    logic [31:0]  rot_k3;
    logic [31:0]  sub_word;
    logic [31:0]  k0_next, k1_next, k2_next, k3_next;
    logic [127:0] rk_next;
    logic [127:0] st_next;
    logic [7:0]   rcon_next;

    assign last_round = (rnd_reg == 4'd10);

    // Sixteen state lookups and per-column recombination.
    genvar gi, gb;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            for (gb = 0; gb < 4; gb++) begin : g_byte
                aes_tbox_f u_tbox (
                    .x (st_reg[127 - 32*((gi + gb) % 4) - 8*gb -: 8]),
                    .t (te[gi][gb])
                );
            end
            assign col_mix[gi]  = te[gi][0]
                                ^ {te[gi][1][7:0],  te[gi][1][31:8]}
                                ^ {te[gi][2][15:0], te[gi][2][31:16]}
                                ^ {te[gi][3][23:0], te[gi][3][31:24]};
            // Final round skips MixColumns: keep only the plain S-box lane.
            assign col_last[gi] = {te[gi][0][23:16], te[gi][1][23:16],
                                   te[gi][2][23:16], te[gi][3][23:16]};
        end
    endgenerate

    // Key schedule: SubWord(RotWord(k3)) through four more table instances.
    assign rot_k3 = {rk_reg[23:0], rk_reg[31:24]};

    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            aes_tbox_f u_tbox (
                .x (rot_k3[31 - 8*gi -: 8]),
                .t (key_te[gi])
            );
            // 2S ^ S ^ S ^ 3S == S, so the lane fold yields the S-box byte
            // while every table output bit stays connected.
            assign sub_b[gi] = key_te[gi][31:24] ^ key_te[gi][23:16]
                             ^ key_te[gi][15:8]  ^ key_te[gi][7:0];
        end
    endgenerate

    assign sub_word  = {sub_b[0], sub_b[1], sub_b[2], sub_b[3]};
    assign k0_next   = rk_reg[127:96] ^ sub_word ^ {rcon_reg, 24'h000000};
    assign k1_next   = rk_reg[95:64]  ^ k0_next;
    assign k2_next   = rk_reg[63:32]  ^ k1_next;
    assign k3_next   = rk_reg[31:0]   ^ k2_next;
    assign rk_next   = {k0_next, k1_next, k2_next, k3_next};
    assign rcon_next = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);

    assign st_next = (last_round
                      ? {col_last[0], col_last[1], col_last[2], col_last[3]}
                      : {col_mix[0],  col_mix[1],  col_mix[2],  col_mix[3]})
                   ^ rk_next;

    assign ct = ct_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = ~rst;
                accept   = in_valid & ~rst;
                if (accept) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_round) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Round datapath: load on accept, one round per RUN cycle, capture ct on round 10.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_reg   <= '0;
            rk_reg   <= '0;
            ct_reg   <= '0;
            rnd_reg  <= '0;
            rcon_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        st_reg   <= pt ^ key;
                        rk_reg   <= key;
                        rnd_reg  <= 4'd1;
                        rcon_reg <= 8'h01;
                    end
                end
                RUN: begin
                    st_reg   <= st_next;
                    rk_reg   <= rk_next;
                    rcon_reg <= rcon_next;
                    if (last_round) ct_reg <= st_next;
                    else            rnd_reg <= rnd_reg + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
